sram_page_writer: RTL and testbench
===================================

Name: sram_page_writer

Overview:
- Ingress write stage directly upstream of sram_state.
- Accepts packet word streams from the 16 ports and packs them into 8-word SRAM pages taken from the null-page FIFO head (null_ptr).
- Pops each page by pulsing wr_op/wr_port, writes the per-page ECC byte through the ecc_wr_* interface, and emits page-link and packet-done records for the downstream queue manager.

Parameters:
- PORT_NUM, 16, number of ingress ports; port index width is 4.
- DATA_WIDTH, 16, width of one SRAM data word.
- PAGE_WORDS, 8, words per page; offset width is 3.
- PAGE_ADDR_WIDTH, 11, page index width (2048 pages).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  ingress word valid.
- in_port  in  4  source port; sampled only on the first word of a packet.
- in_data  in  16  ingress word.
- in_last  in  1  last word of packet.
- in_ready  out  1  word accepted when in_valid && in_ready.
- null_ptr  in  11  free-page FIFO head, from sram_state.
- free_space  in  11  free page count, from sram_state.
- wr_op  out  1  one-cycle page-pop pulse, to sram_state.
- wr_port  out  4  owning port of the popped page.
- sram_wr_en  out  1  data SRAM write strobe.
- sram_wr_addr  out  14  {page, offset}.
- sram_din  out  16  data to SRAM.
- ecc_wr_en  out  1  ECC storage write strobe.
- ecc_wr_addr  out  11  page index.
- ecc_din  out  8  page ECC byte.
- link_wr_en  out  1  intra-packet page link valid.
- link_prev  out  11  previous page.
- link_next  out  11  newly allocated page.
- pkt_done  out  1  packet complete pulse.
- pkt_port  out  4  packet's port.
- pkt_head  out  11  first page of the packet.
- pkt_pages  out  11  pages used by the packet.

Behaviour:
- Reset is asynchronous. All outputs are 0, state is IDLE, offset is 0, and the ECC accumulator is 0.
- FSM states: IDLE (no open packet), WRITE (packet open), CLOSE (one-cycle gap after in_last).
- in_ready:
  - IDLE: free_space != 0.
  - WRITE: offset != 0 || free_space != 0.
  - CLOSE: 0.
- Allocation happens when a word is accepted at offset 0:
  - cur_page := null_ptr.
  - Next cycle: wr_op=1 and wr_port=latched port.
  - If this is not the packet's first page, next cycle also link_wr_en=1 with link_prev=old cur_page and link_next=null_ptr.
  - On the first page, pkt_head := null_ptr and pkt_port := in_port, both latched.
- Every accepted word produces sram_wr_en=1 in the following cycle, with sram_wr_addr={cur_page, offset} and sram_din=in_data. Latency is 1 cycle and all outputs are registered.
- offset increments per accepted word and wraps 7 -> 0.
- ECC byte is the XOR over the page's words of (word[15:8] ^ word[7:0]). It is computed over the words actually written.
- A page closes when offset==7 is accepted or in_last is accepted. On the next cycle: ecc_wr_en=1, ecc_wr_addr=cur_page, ecc_din=final accumulator. The accumulator then clears.
- On in_last accept:
  - Next cycle: pkt_done=1 with pkt_head, pkt_port, and pkt_pages (11-bit count including the current page).
  - State goes to CLOSE for exactly one cycle, then IDLE, with offset reset to 0.
  - The CLOSE gap guarantees null_ptr/free_space reflect the previous pop before the next allocation.
- Back-to-back pages within a packet are at least 8 cycles apart, so no extra gap is needed.
- free_space==0 at a needed allocation: in_ready stays low and the word is held (stall). There is no drop.
- in_port changes mid-packet are ignored; the latched port is used.
- Reset mid-packet discards the partial packet. No pkt_done, ECC, or link write is issued.
- Pages are never freed here; freeing is owned by the read side via rd_op.

Optional Feature:
- Macro PAGE_WRITER_STATS_EN.
- When defined, adds outputs stat_pkts (32-bit) and stat_stall_cycles (32-bit).
  - stat_pkts: count of pkt_done pulses.
  - stat_stall_cycles: count of cycles with in_valid && !in_ready && state!=CLOSE.
  - Both saturate at all-ones and clear on reset.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package holds: PORT_NUM, PAGE_WORDS, PAGE_ADDR_WIDTH, DATA_WIDTH, port_t (logic [3:0]), page_t (logic [10:0]), and the writer FSM state enum.
- One natural sub-module: page_ecc_acc, holding the ECC accumulator with clear/accumulate/output.

Test Plan:
- Three-word packet, port 5, null_ptr=100: single wr_op with wr_port=5; SRAM writes to addresses 800..802; one ecc_wr_en with ecc_wr_addr=100; pkt_done with head 100, pages 1.
- Nine-word packet, port 2, null_ptr 7 then 9: wr_op fires twice; link 7->9; ECC written for page 7 after word 8 and for page 9 after word 9; pkt_pages=2.
- Stall case, free_space=0 with in_valid high: in_ready=0 and no writes. Raise free_space to 1: word accepted the next cycle.
- Two back-to-back single-word packets: one CLOSE cycle between them; the second allocation uses the updated null_ptr.
- Words 0x1234 and 0x00FF in one page: ecc_din = 0x26 ^ 0xFF = 0xD9.
- Assert rst_n low mid-packet after 4 words: all outputs 0 immediately; no pkt_done or ECC write follows; next packet starts at offset 0.

Source files
------------

// File: rtl/sram_page_writer_pkg.sv
// Shared types and constants for the SRAM ingress page writer.
// Build option: PAGE_WRITER_STATS_EN adds packet and stall counters to the top.
package sram_page_writer_pkg;

  localparam int PORT_NUM        = 16;
  localparam int DATA_WIDTH      = 16;
  localparam int PAGE_WORDS      = 8;
  localparam int PAGE_ADDR_WIDTH = 11;
  localparam int PORT_W          = $clog2(PORT_NUM);
  localparam int OFFSET_W        = $clog2(PAGE_WORDS);
  localparam int SRAM_ADDR_W     = PAGE_ADDR_WIDTH + OFFSET_W;

  typedef logic [PORT_W-1:0]          port_t;
  typedef logic [PAGE_ADDR_WIDTH-1:0] page_t;
  typedef logic [DATA_WIDTH-1:0]      data_t;
  typedef logic [OFFSET_W-1:0]        offset_t;
  typedef logic [7:0]                 ecc_t;

  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_WRITE = 2'd1,
    WR_CLOSE = 2'd2
  } wr_state_e;

  // Every registered output of the writer, updated together each cycle.
  typedef struct packed {
    logic                   wr_op;
    port_t                  wr_port;
    logic                   sram_wr_en;
    logic [SRAM_ADDR_W-1:0] sram_wr_addr;
    data_t                  sram_din;
    logic                   ecc_wr_en;
    page_t                  ecc_wr_addr;
    ecc_t                   ecc_din;
    logic                   link_wr_en;
    page_t                  link_prev;
    page_t                  link_next;
    logic                   pkt_done;
    port_t                  pkt_port;
    page_t                  pkt_head;
    page_t                  pkt_pages;
  } wr_out_t;

  function automatic ecc_t ecc_fold(input data_t w);
    return w[15:8] ^ w[7:0];
  endfunction

endpackage

// File: rtl/sram_page_writer_if.sv
// Ingress word stream into the page writer: valid/ready handshake plus payload.
interface sram_page_writer_if;
  import sram_page_writer_pkg::*;

  logic  in_valid;
  port_t in_port;
  data_t in_data;
  logic  in_last;
  logic  in_ready;

  modport master (output in_valid, in_port, in_data, in_last, input in_ready);
  modport slave  (input in_valid, in_port, in_data, in_last, output in_ready);
endinterface

// File: rtl/sram_page_writer_page_ecc_acc.sv
// Per-page ECC accumulator: XOR of folded words, cleared when the page closes.
module page_ecc_acc
  import sram_page_writer_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  word_en,
  input  logic  page_close,
  input  data_t word,
  output ecc_t  ecc_next
);

  ecc_t acc_q, acc_d;

  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    ecc_next = acc_q ^ ecc_fold(word);
    acc_d    = acc_q;
    if (word_en) acc_d = page_close ? '0 : ecc_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

endmodule

// File: rtl/sram_page_writer.sv
// Packs ingress packet words into 8-word SRAM pages, popping pages and emitting ECC/link/done records.
// Build option: PAGE_WRITER_STATS_EN adds stat_pkts and stat_stall_cycles outputs.
module sram_page_writer
  import sram_page_writer_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  sram_page_writer_if.slave      in_if,
  input  page_t                  null_ptr,
  input  page_t                  free_space,
  output logic                   wr_op,
  output port_t                  wr_port,
  output logic                   sram_wr_en,
  output logic [SRAM_ADDR_W-1:0] sram_wr_addr,
  output data_t                  sram_din,
  output logic                   ecc_wr_en,
  output page_t                  ecc_wr_addr,
  output ecc_t                   ecc_din,
  output logic                   link_wr_en,
  output page_t                  link_prev,
  output page_t                  link_next,
  output logic                   pkt_done,
  output port_t                  pkt_port,
  output page_t                  pkt_head,
  output page_t                  pkt_pages
`ifdef PAGE_WRITER_STATS_EN
  ,
  output logic [31:0]            stat_pkts,
  output logic [31:0]            stat_stall_cycles
`endif
);

  localparam logic [1:0] S_IDLE  = 2'(WR_IDLE);
  localparam logic [1:0] S_WRITE = 2'(WR_WRITE);
  localparam logic [1:0] S_CLOSE = 2'(WR_CLOSE);

  logic [1:0] state_q, state_d;
  offset_t    offset_q, offset_d;
  page_t      cur_page_q, cur_page_d;
  page_t      head_q, head_d;
  page_t      pages_q, pages_d;
  port_t      port_q, port_d;
  wr_out_t    out_q, out_d;

  logic ready, accept, first, alloc, last, page_close;
  ecc_t ecc_next;

  // Ready is forced low under reset so every output reads 0 while rst_n is asserted.
  assign ready = rst_n && ((state_q == S_IDLE  && free_space != '0) ||
                           (state_q == S_WRITE && (offset_q != '0 || free_space != '0)));
  assign in_if.in_ready = ready;

  assign accept     = in_if.in_valid && ready;
  assign first      = (state_q == S_IDLE);
  assign alloc      = accept && (offset_q == '0);
  assign last       = accept && in_if.in_last;
  assign page_close = accept && (offset_q == offset_t'(PAGE_WORDS - 1) || in_if.in_last);

  page_ecc_acc u_ecc (
    .clk        (clk),
    .rst_n      (rst_n),
    .word_en    (accept),
    .page_close (page_close),
    .word       (in_if.in_data),
    .ecc_next   (ecc_next)
  );

  always_comb begin
    state_d    = state_q;
    offset_d   = offset_q;
    cur_page_d = cur_page_q;
    head_d     = head_q;
    pages_d    = pages_q;
    port_d     = port_q;
    out_d      = out_q;
    out_d.wr_op      = 1'b0;
    out_d.sram_wr_en = 1'b0;
    out_d.ecc_wr_en  = 1'b0;
    out_d.link_wr_en = 1'b0;
    out_d.pkt_done   = 1'b0;

    if (alloc) begin
      cur_page_d  = null_ptr;
      out_d.wr_op = 1'b1;
      if (first) begin
        head_d  = null_ptr;
        port_d  = in_if.in_port;
        pages_d = page_t'(1);
      end else begin
        pages_d          = pages_q + page_t'(1);
        out_d.link_wr_en = 1'b1;
        out_d.link_prev  = cur_page_q;
        out_d.link_next  = null_ptr;
      end
      out_d.wr_port = port_d;
    end

    if (accept) begin
      out_d.sram_wr_en   = 1'b1;
      out_d.sram_wr_addr = {cur_page_d, offset_q};
      out_d.sram_din     = in_if.in_data;
      offset_d           = last ? '0 : offset_q + offset_t'(1);
    end

    if (page_close) begin
      out_d.ecc_wr_en   = 1'b1;
      out_d.ecc_wr_addr = cur_page_d;
      out_d.ecc_din     = ecc_next;
    end

    if (last) begin
      out_d.pkt_done  = 1'b1;
      out_d.pkt_head  = head_d;
      out_d.pkt_port  = port_d;
      out_d.pkt_pages = pages_d;
    end

    case (state_q)
      S_IDLE:  if (accept) state_d = last ? S_CLOSE : S_WRITE;
      S_WRITE: if (last)   state_d = S_CLOSE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      offset_q   <= '0;
      cur_page_q <= '0;
      head_q     <= '0;
      pages_q    <= '0;
      port_q     <= '0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      offset_q   <= offset_d;
      cur_page_q <= cur_page_d;
      head_q     <= head_d;
      pages_q    <= pages_d;
      port_q     <= port_d;
      out_q      <= out_d;
    end
  end

  assign wr_op        = out_q.wr_op;
  assign wr_port      = out_q.wr_port;
  assign sram_wr_en   = out_q.sram_wr_en;
  assign sram_wr_addr = out_q.sram_wr_addr;
  assign sram_din     = out_q.sram_din;
  assign ecc_wr_en    = out_q.ecc_wr_en;
  assign ecc_wr_addr  = out_q.ecc_wr_addr;
  assign ecc_din      = out_q.ecc_din;
  assign link_wr_en   = out_q.link_wr_en;
  assign link_prev    = out_q.link_prev;
  assign link_next    = out_q.link_next;
  assign pkt_done     = out_q.pkt_done;
  assign pkt_port     = out_q.pkt_port;
  assign pkt_head     = out_q.pkt_head;
  assign pkt_pages    = out_q.pkt_pages;

`ifdef PAGE_WRITER_STATS_EN
  logic [31:0] stat_pkts_q, stat_pkts_d, stat_stall_q, stat_stall_d;

  // Counters saturate rather than wrap.
  always_comb begin
    stat_pkts_d  = stat_pkts_q;
    stat_stall_d = stat_stall_q;
    if (out_d.pkt_done && stat_pkts_q != '1) stat_pkts_d = stat_pkts_q + 32'd1;
    if (in_if.in_valid && !ready && state_q != S_CLOSE && stat_stall_q != '1)
      stat_stall_d = stat_stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pkts_q  <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_pkts_q  <= stat_pkts_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_pkts         = stat_pkts_q;
  assign stat_stall_cycles = stat_stall_q;
`endif

endmodule

// File: tb/tb_sram_page_writer.sv
// Directed and randomized checks of sram_page_writer against a packet-level reference model.
module tb_sram_page_writer;
  import sram_page_writer_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sram_page_writer_if in_if ();
  page_t null_ptr, free_space;
  logic wr_op, sram_wr_en, ecc_wr_en, link_wr_en, pkt_done;
  port_t wr_port, pkt_port;
  logic [SRAM_ADDR_W-1:0] sram_wr_addr;
  data_t sram_din;
  page_t ecc_wr_addr, link_prev, link_next, pkt_head, pkt_pages;
  ecc_t ecc_din;
`ifdef PAGE_WRITER_STATS_EN
  logic [31:0] stat_pkts, stat_stall_cycles;
`endif

  sram_page_writer dut (
    .clk (clk), .rst_n (rst_n), .in_if (in_if),
    .null_ptr (null_ptr), .free_space (free_space),
    .wr_op (wr_op), .wr_port (wr_port),
    .sram_wr_en (sram_wr_en), .sram_wr_addr (sram_wr_addr), .sram_din (sram_din),
    .ecc_wr_en (ecc_wr_en), .ecc_wr_addr (ecc_wr_addr), .ecc_din (ecc_din),
    .link_wr_en (link_wr_en), .link_prev (link_prev), .link_next (link_next),
    .pkt_done (pkt_done), .pkt_port (pkt_port), .pkt_head (pkt_head), .pkt_pages (pkt_pages)
`ifdef PAGE_WRITER_STATS_EN
    , .stat_pkts (stat_pkts), .stat_stall_cycles (stat_stall_cycles)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Reference model: packet phase, words placed in the open page, page list of the open packet.
  typedef enum {M_IDLE, M_OPEN, M_GAP} m_phase_e;
  m_phase_e m_phase;
  int       m_words;
  page_t    m_pages[$];
  data_t    m_page_data[$];
  port_t    m_port;
  int       m_pkts, m_stalls;

  // Observation logs for directed end-of-scenario checks.
  logic [SRAM_ADDR_W-1:0] log_sram[$];
  page_t  log_ecc_addr[$];
  ecc_t   log_ecc_din[$];
  logic [21:0] log_link[$];
  int     n_wr_op, n_done;
  page_t  last_head, last_pages;
  port_t  last_port;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic ecc_t model_page_ecc();
    ecc_t e = '0;
    foreach (m_page_data[i]) e ^= m_page_data[i][15:8] ^ m_page_data[i][7:0];
    return e;
  endfunction

  task automatic model_reset();
    m_phase = M_IDLE;
    m_words = 0;
    m_pages.delete();
    m_page_data.delete();
    m_pkts = 0;
    m_stalls = 0;
  endtask

  task automatic clear_logs();
    log_sram.delete(); log_ecc_addr.delete(); log_ecc_din.delete(); log_link.delete();
    n_wr_op = 0; n_done = 0;
  endtask

  task automatic check_all_zero();
    check("rst_in_ready", in_if.in_ready, 0);
    check("rst_wr_op", wr_op, 0);
    check("rst_wr_port", wr_port, 0);
    check("rst_sram_wr_en", sram_wr_en, 0);
    check("rst_sram_wr_addr", sram_wr_addr, 0);
    check("rst_sram_din", sram_din, 0);
    check("rst_ecc_wr_en", ecc_wr_en, 0);
    check("rst_ecc_din", ecc_din, 0);
    check("rst_link_wr_en", link_wr_en, 0);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_pkt_head", pkt_head, 0);
    check("rst_pkt_pages", pkt_pages, 0);
  endtask

  // One clock cycle: drive, predict from the model, clock, compare, log.
  task automatic step(input logic v, input port_t p, input data_t d, input logic l, output logic acc);
    logic e_ready, e_wr_op = 0, e_link = 0, e_sram = 0, e_ecc = 0, e_done = 0;
    port_t e_wr_port = '0, e_port = '0;
    page_t e_prev = '0, e_next = '0, e_ecc_addr = '0, e_head = '0, e_pages = '0;
    logic [SRAM_ADDR_W-1:0] e_addr = '0;
    ecc_t e_ecc_din = '0;
    in_if.in_valid = v; in_if.in_port = p; in_if.in_data = d; in_if.in_last = l;
    #1;
    e_ready = (m_phase == M_IDLE) ? (free_space != 0) :
              (m_phase == M_OPEN) ? (m_words != 0 || free_space != 0) : 1'b0;
    check("in_ready", in_if.in_ready, e_ready);
    acc = v && e_ready;
    if (v && !e_ready && m_phase != M_GAP) m_stalls++;
    if (acc) begin
      if (m_words == 0) begin
        if (m_phase == M_IDLE) begin
          m_pages.delete();
          m_port = p;
        end else begin
          e_link = 1; e_prev = m_pages[$]; e_next = null_ptr;
        end
        m_pages.push_back(null_ptr);
        e_wr_op = 1; e_wr_port = m_port;
      end
      e_sram = 1;
      e_addr = {m_pages[$], 3'(m_words)};
      m_page_data.push_back(d);
      if (m_words == 7 || l) begin
        e_ecc = 1; e_ecc_addr = m_pages[$]; e_ecc_din = model_page_ecc();
        m_page_data.delete();
        m_words = 0;
      end else m_words++;
      if (l) begin
        e_done = 1; e_head = m_pages[0]; e_port = m_port; e_pages = page_t'(m_pages.size());
        m_pkts++;
        m_phase = M_GAP;
      end else m_phase = M_OPEN;
    end else if (m_phase == M_GAP) m_phase = M_IDLE;

    @(posedge clk);
    #1;
    check("wr_op", wr_op, e_wr_op);
    if (e_wr_op) check("wr_port", wr_port, e_wr_port);
    check("sram_wr_en", sram_wr_en, e_sram);
    if (e_sram) begin
      check("sram_wr_addr", sram_wr_addr, e_addr);
      check("sram_din", sram_din, d);
    end
    check("ecc_wr_en", ecc_wr_en, e_ecc);
    if (e_ecc) begin
      check("ecc_wr_addr", ecc_wr_addr, e_ecc_addr);
      check("ecc_din", ecc_din, e_ecc_din);
    end
    check("link_wr_en", link_wr_en, e_link);
    if (e_link) begin
      check("link_prev", link_prev, e_prev);
      check("link_next", link_next, e_next);
    end
    check("pkt_done", pkt_done, e_done);
    if (e_done) begin
      check("pkt_head", pkt_head, e_head);
      check("pkt_port", pkt_port, e_port);
      check("pkt_pages", pkt_pages, e_pages);
    end

    if (sram_wr_en) log_sram.push_back(sram_wr_addr);
    if (ecc_wr_en) begin log_ecc_addr.push_back(ecc_wr_addr); log_ecc_din.push_back(ecc_din); end
    if (link_wr_en) log_link.push_back({link_prev, link_next});
    if (wr_op) n_wr_op++;
    if (pkt_done) begin n_done++; last_head = pkt_head; last_pages = pkt_pages; last_port = pkt_port; end
  endtask

  // Hold a word until accepted; in random mode the free-page environment changes each cycle.
  task automatic send_word(input port_t p, input data_t d, input logic l, input bit rand_env,
                           output int waited);
    logic acc = 0;
    waited = 0;
    while (!acc && waited < 64) begin
      if (rand_env) begin
        null_ptr   = page_t'($urandom);
        free_space = ($urandom_range(0, 3) == 0) ? '0 : page_t'($urandom_range(1, 2047));
      end
      step(1'b1, p, d, l, acc);
      if (!acc) waited++;
    end
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, acc);
  endtask

  initial begin
    int w;
    logic acc;
    rst_n = 1'b0;
    in_if.in_valid = 0; in_if.in_port = '0; in_if.in_data = '0; in_if.in_last = 0;
    null_ptr = '0; free_space = 11'd20;
    model_reset();
    clear_logs();
    #2;
    check_all_zero();
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Three-word packet, port 5, page 100.
    clear_logs();
    null_ptr = 11'd100;
    for (int i = 0; i < 3; i++) send_word(4'd5, data_t'($urandom), i == 2, 0, w);
    idle(2);
    check("a_wr_ops", n_wr_op, 1);
    check("a_nsram", log_sram.size(), 3);
    check("a_addr0", log_sram[0], 800);
    check("a_addr2", log_sram[2], 802);
    check("a_necc", log_ecc_addr.size(), 1);
    check("a_ecc_addr", log_ecc_addr[0], 100);
    check("a_head", last_head, 100);
    check("a_pages", last_pages, 1);
    check("a_port", last_port, 5);

    // Nine-word packet spanning pages 7 and 9.
    clear_logs();
    null_ptr = 11'd7;
    send_word(4'd2, data_t'($urandom), 0, 0, w);
    null_ptr = 11'd9;
    for (int i = 1; i < 9; i++) send_word(4'($urandom), data_t'($urandom), i == 8, 0, w);
    idle(2);
    check("b_wr_ops", n_wr_op, 2);
    check("b_nlink", log_link.size(), 1);
    check("b_link", log_link[0], 32'({11'd7, 11'd9}));
    check("b_ecc0", log_ecc_addr[0], 7);
    check("b_ecc1", log_ecc_addr[1], 9);
    check("b_pages", last_pages, 2);
    check("b_port", last_port, 2);

    // Stall on empty free list, release when a page appears.
    clear_logs();
    free_space = '0;
    null_ptr = 11'd33;
    for (int i = 0; i < 3; i++) step(1'b1, 4'd3, 16'hBEEF, 1'b1, acc);
    check("c_no_writes", log_sram.size(), 0);
    free_space = 11'd1;
    step(1'b1, 4'd3, 16'hBEEF, 1'b1, acc);
    check("c_released", acc, 1);
    free_space = 11'd20;
    idle(2);

    // Back-to-back single-word packets with exactly one CLOSE cycle between.
    clear_logs();
    null_ptr = 11'd40;
    send_word(4'd1, 16'h0001, 1, 0, w);
    null_ptr = 11'd41;
    send_word(4'd4, 16'h0002, 1, 0, w);
    check("d_gap_cycles", w, 1);
    check("d_addr1", log_sram[1], 32'({11'd41, 3'd0}));
    idle(2);

    // ECC over two words: 0x12^0x34 ^ 0x00^0xFF = 0xD9.
    clear_logs();
    null_ptr = 11'd60;
    send_word(4'd6, 16'h1234, 0, 0, w);
    send_word(4'd6, 16'h00FF, 1, 0, w);
    idle(2);
    check("e_ecc_din", log_ecc_din[0], 8'hD9);

    // Reset in the middle of a packet after four words.
    null_ptr = 11'd70;
    for (int i = 0; i < 4; i++) send_word(4'd8, data_t'($urandom), 0, 0, w);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero();
    model_reset();
    clear_logs();
    @(posedge clk); #1;
    check("rst_hold_sram", sram_wr_en, 0);
    rst_n = 1'b1;
    idle(3);
    check("rst_no_done", n_done, 0);
    check("rst_no_ecc", log_ecc_addr.size(), 0);
    null_ptr = 11'd55;
    send_word(4'd9, 16'h5555, 1, 0, w);
    idle(2);
    check("rst_restart_addr", log_sram[0], 32'({11'd55, 3'd0}));

    // Randomized packets with gaps, mid-packet port changes and free-list stalls.
    for (int p = 0; p < 40; p++) begin
      int len = $urandom_range(1, 20);
      port_t port = port_t'($urandom);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        send_word((i == 0) ? port : port_t'($urandom), data_t'($urandom), i == len - 1, 1, w);
      end
    end
    free_space = 11'd20;
    idle(3);

`ifdef PAGE_WRITER_STATS_EN
    check("stat_pkts", stat_pkts, m_pkts);
    check("stat_stall_cycles", stat_stall_cycles, m_stalls);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
